// File: rtl/acia_host_sequencer.sv
// Bus master for one acia: programs the control register, then polls status,
// drains received bytes and writes round-robin arbitrated requester bytes to the TDR.
module acia_host_sequencer #(
    parameter logic [7:0] CR_INIT = 8'h15,
    parameter int         E_DIV   = 4,
    parameter logic [5:0] SETTLE  = 6'd32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [1:0] rx_err,
    output logic       init_done,
    output logic       acia_E,
    output logic       acia_sel,
    output logic       acia_rs,
    output logic       acia_rw,
    output logic [7:0] acia_din,
    input  logic [7:0] acia_dout
);

    typedef enum logic [2:0] {
        S_MR,
        S_CFG,
        S_STAT,
        S_DECIDE,
        S_RDATA,
        S_WDATA,
        S_WAIT
    } state_t;

    // Phase counter is one bit wider than 4 so that E_DIV up to 15 still fits 2*E_DIV-1.
    localparam int            PW      = 5;
    localparam logic [PW-1:0] PH_LAST = PW'(2 * E_DIV - 1);
    localparam logic [PW-1:0] PH_E    = PW'(E_DIV);

    state_t        r_state;
    state_t        w_state_next;

    logic [PW-1:0] r_phase;
    logic          r_active;
    logic          r_sel;
    logic          r_rs;
    logic          r_rw;
    logic [7:0]    r_din;

    logic          r_rdrf;
    logic          r_tdre;
    logic [1:0]    r_st_err;
    logic [5:0]    r_settle;
    logic          r_rr;
    logic          r_win;
    logic [7:0]    r_tx_byte;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic [1:0]    r_rx_err;
    logic          r_init_done;

    logic          w_done;
    logic          w_bus_en;
    logic          w_bus_rs;
    logic          w_bus_rw;
    logic [7:0]    w_bus_din;
    logic          w_grant;
    logic          w_pick1;

    assign w_done  = r_active && (r_phase == PH_LAST);
    assign w_grant = (r_state == S_DECIDE) && !r_rdrf && r_tdre && (req0 || req1);
    assign w_pick1 = req1 && (!req0 || r_rr);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_MR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_MR:     if (w_done) w_state_next = S_CFG;
            S_CFG:    if (w_done) w_state_next = S_STAT;
            S_STAT:   if (w_done) w_state_next = S_DECIDE;
            S_DECIDE: begin
                if (r_rdrf) begin
                    w_state_next = S_RDATA;
                end else if (r_tdre && (req0 || req1)) begin
                    w_state_next = S_WDATA;
                end else begin
                    w_state_next = S_STAT;
                end
            end
            S_RDATA:  if (w_done) w_state_next = S_STAT;
            S_WDATA:  if (w_done) w_state_next = S_WAIT;
            S_WAIT:   if (r_settle == (SETTLE - 6'd1)) w_state_next = S_STAT;
            default:  w_state_next = S_MR;
        endcase
    end

    // Output decode: which bus cycle the current state wants
    always_comb begin
        w_bus_en  = 1'b0;
        w_bus_rs  = 1'b0;
        w_bus_rw  = 1'b1;
        w_bus_din = 8'h00;
        case (r_state)
            S_MR: begin
                w_bus_en  = 1'b1;
                w_bus_rw  = 1'b0;
                w_bus_din = 8'h03;
            end
            S_CFG: begin
                w_bus_en  = 1'b1;
                w_bus_rw  = 1'b0;
                w_bus_din = CR_INIT;
            end
            S_STAT: begin
                w_bus_en  = 1'b1;
            end
            S_RDATA: begin
                w_bus_en  = 1'b1;
                w_bus_rs  = 1'b1;
            end
            S_WDATA: begin
                w_bus_en  = 1'b1;
                w_bus_rs  = 1'b1;
                w_bus_rw  = 1'b0;
                w_bus_din = r_tx_byte;
            end
            default: begin
                w_bus_en  = 1'b0;
            end
        endcase
    end

    // Bus cycle engine; a new cycle only starts from idle, giving one sel-low clk between cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_phase  <= '0;
            r_sel    <= 1'b0;
            r_rs     <= 1'b0;
            r_rw     <= 1'b1;
            r_din    <= 8'h00;
        end else if (r_active) begin
            if (w_done) begin
                r_active <= 1'b0;
                r_sel    <= 1'b0;
                r_phase  <= '0;
            end else begin
                r_phase  <= r_phase + 1'b1;
            end
        end else if (w_bus_en) begin
            r_active <= 1'b1;
            r_sel    <= 1'b1;
            r_phase  <= '0;
            r_rs     <= w_bus_rs;
            r_rw     <= w_bus_rw;
            r_din    <= w_bus_din;
        end
    end

    // Status latch, arbitration, receive capture and settle timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdrf      <= 1'b0;
            r_tdre      <= 1'b0;
            r_st_err    <= 2'b00;
            r_settle    <= 6'd0;
            r_rr        <= 1'b0;
            r_win       <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_rx_err    <= 2'b00;
            r_init_done <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_done && (r_state == S_CFG)) begin
                r_init_done <= 1'b1;
            end
            if (w_done && (r_state == S_STAT)) begin
                r_rdrf   <= acia_dout[0];
                r_tdre   <= acia_dout[1];
                r_st_err <= acia_dout[5:4];
            end
            if (w_done && (r_state == S_RDATA)) begin
                r_rx_data  <= acia_dout;
                r_rx_err   <= r_st_err;
                r_rx_valid <= 1'b1;
            end
            if (w_grant) begin
                r_win     <= w_pick1;
                r_tx_byte <= w_pick1 ? data1 : data0;
                if (req0 && req1) begin
                    r_rr <= ~r_rr;
                end
            end
            if (r_state == S_WAIT) begin
                r_settle <= r_settle + 6'd1;
            end else begin
                r_settle <= 6'd0;
            end
        end
    end

    assign acia_E    = r_active && (r_phase >= PH_E);
    assign acia_sel  = r_sel;
    assign acia_rs   = r_rs;
    assign acia_rw   = r_rw;
    assign acia_din  = r_din;
    // Ack marks the TDR write completing this clk; suppressed if reset aborts it.
    assign ack0      = w_done && (r_state == S_WDATA) && !r_win && !reset;
    assign ack1      = w_done && (r_state == S_WDATA) &&  r_win && !reset;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_err    = r_rx_err;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_acia_host_sequencer.sv
// Directed bench for acia_host_sequencer with a small behavioural acia register model.
module tb_acia_host_sequencer;

    localparam int E_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       ack0, ack1, rx_valid, init_done;
    logic       acia_E, acia_sel, acia_rs, acia_rw;
    logic [7:0] rx_data, acia_din, acia_dout;
    logic [1:0] rx_err;

    acia_host_sequencer #(.CR_INIT(8'h15), .E_DIV(E_DIV), .SETTLE(6'd32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .init_done(init_done),
        .acia_E(acia_E), .acia_sel(acia_sel), .acia_rs(acia_rs), .acia_rw(acia_rw),
        .acia_din(acia_din), .acia_dout(acia_dout)
    );

    always #5 clk = ~clk;

    // acia register model
    logic [7:0] m_rdr = 8'h00;
    logic [7:0] m_cr = 8'h00;
    logic       m_rdrf = 1'b0;
    logic       m_tdre_low = 1'b0;
    logic       m_loop = 1'b0;
    logic [1:0] m_err = 2'b00;

    assign acia_dout = (acia_sel && acia_rw) ?
                       (acia_rs ? m_rdr : {2'b00, m_err, 2'b00, ~m_tdre_low, m_rdrf}) : 8'h00;

    logic [9:0] bus_log[$];
    logic [7:0] tx_log[$];
    int         ack_log[$];
    logic [9:0] rx_log[$];
    int         len_log[$];
    int         e_log[$];
    int         cyc = 0;
    int         ack_cyc = 0;
    int         rx_cyc = 0;
    int         sel_cnt = 0;
    int         e_cnt = 0;
    int         viol = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (acia_sel) begin
                sel_cnt++;
                if (acia_E) e_cnt++;
            end else begin
                if (sel_cnt > 0) len_log.push_back(sel_cnt);
                sel_cnt = 0;
                e_cnt = 0;
            end
            if (sel_cnt == 2 * E_DIV) begin
                bus_log.push_back({acia_rw, acia_rs, acia_din});
                e_log.push_back(e_cnt);
                if (!acia_rw) begin
                    if (!acia_rs) begin
                        m_cr = (acia_din == 8'h03) ? 8'h00 : acia_din;
                        $display("[%0d] CR write %02h", cyc, acia_din);
                    end else begin
                        tx_log.push_back(acia_din);
                        $display("[%0d] TDR write %02h", cyc, acia_din);
                        if (m_tdre_low) viol++;
                        if (m_loop) begin
                            m_rdr = acia_din;
                            m_rdrf = 1'b1;
                        end
                    end
                end else if (acia_rs) begin
                    m_rdrf = 1'b0;
                end
            end
            if (ack0 && ack1) viol++;
            if ((ack0 || ack1) && rx_valid) viol++;
            if (ack0) begin ack_log.push_back(0); ack_cyc = cyc; $display("[%0d] ack0", cyc); end
            if (ack1) begin ack_log.push_back(1); ack_cyc = cyc; $display("[%0d] ack1", cyc); end
            if (rx_valid) begin
                rx_log.push_back({rx_err, rx_data});
                rx_cyc = cyc;
                $display("[%0d] rx_valid data=%02h err=%0b", cyc, rx_data, rx_err);
            end
        end
    end

    task automatic clear_logs();
        bus_log.delete(); tx_log.delete(); ack_log.delete();
        rx_log.delete(); len_log.delete(); e_log.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_cmp++;
        if ({acia_E, acia_sel, acia_rs, acia_rw, acia_din} !== {4'b0001, 8'h00}) begin
            n_err++; $display("FAIL reset_bus got=%03h want=%03h", {acia_E, acia_sel, acia_rs, acia_rw, acia_din}, {4'b0001, 8'h00});
        end
        n_cmp++;
        if ({ack0, ack1, rx_valid, init_done} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got=%04b want=0000", {ack0, ack1, rx_valid, init_done});
        end
        n_cmp++;
        if ({rx_err, rx_data} !== 10'h000) begin
            n_err++; $display("FAIL reset_rx got=%03h want=000", {rx_err, rx_data});
        end
    endtask

    task automatic test_init();
        clear_logs();
        reset = 1'b0;
        for (int i = 0; i < 100 && bus_log.size() < 1; i++) tick(1);
        n_cmp++;
        if (init_done !== 1'b0) begin n_err++; $display("FAIL init_early got=%0b want=0", init_done); end
        for (int i = 0; i < 100 && bus_log.size() < 2; i++) tick(1);
        tick(2);
        n_cmp++;
        if (bus_log.size() < 2) begin n_err++; $display("FAIL init_timeout got=%0d want=2 cycles", bus_log.size()); end
        n_cmp++;
        if (bus_log[0] !== 10'h003) begin n_err++; $display("FAIL init_mr got=%03h want=003", bus_log[0]); end
        n_cmp++;
        if (bus_log[1] !== 10'h015) begin n_err++; $display("FAIL init_cfg got=%03h want=015", bus_log[1]); end
        n_cmp++;
        if (len_log[0] !== 8 || len_log[1] !== 8) begin
            n_err++; $display("FAIL init_len got=%0d,%0d want=8,8", len_log[0], len_log[1]);
        end
        n_cmp++;
        if (e_log[0] !== E_DIV) begin n_err++; $display("FAIL init_e_high got=%0d want=%0d", e_log[0], E_DIV); end
        n_cmp++;
        if (init_done !== 1'b1) begin n_err++; $display("FAIL init_done got=%0b want=1", init_done); end
        n_cmp++;
        if (m_cr !== 8'h15) begin n_err++; $display("FAIL init_cr got=%02h want=15", m_cr); end
    endtask

    task automatic test_loopback();
        clear_logs();
        m_loop = 1'b1;
        data0 = 8'hA5;
        req0 = 1'b1;
        for (int i = 0; i < 300 && ack_log.size() < 1; i++) tick(1);
        req0 = 1'b0;
        for (int i = 0; i < 300 && rx_log.size() < 1; i++) tick(1);
        tick(60);
        m_loop = 1'b0;
        n_cmp++;
        if (ack_log.size() !== 1 || ack_log[0] !== 0) begin
            n_err++; $display("FAIL loop_ack got=%0d acks first=%0d want=1 ack0", ack_log.size(), ack_log[0]);
        end
        n_cmp++;
        if (tx_log.size() !== 1 || tx_log[0] !== 8'hA5) begin
            n_err++; $display("FAIL loop_tx got=%0d bytes first=%02h want=1 A5", tx_log.size(), tx_log[0]);
        end
        n_cmp++;
        if (rx_log.size() !== 1 || rx_log[0] !== 10'h0A5) begin
            n_err++; $display("FAIL loop_rx got=%0d first=%03h want=1 0A5", rx_log.size(), rx_log[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_tx [4];
        exp_tx[0] = 8'h11; exp_tx[1] = 8'h22; exp_tx[2] = 8'h11; exp_tx[3] = 8'h22;
        clear_logs();
        data0 = 8'h11;
        data1 = 8'h22;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 1000 && ack_log.size() < 4; i++) tick(1);
        req0 = 1'b0;
        req1 = 1'b0;
        tick(100);
        n_cmp++;
        if (ack_log.size() !== 4) begin n_err++; $display("FAIL rr_count got=%0d want=4", ack_log.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ack_log[i] !== (i % 2)) begin n_err++; $display("FAIL rr_ack%0d got=%0d want=%0d", i, ack_log[i], i % 2); end
            n_cmp++;
            if (tx_log[i] !== exp_tx[i]) begin n_err++; $display("FAIL rr_tx%0d got=%02h want=%02h", i, tx_log[i], exp_tx[i]); end
        end
    endtask

    task automatic test_tdre_block();
        int stat_reads;
        clear_logs();
        m_tdre_low = 1'b1;
        data1 = 8'h33;
        req1 = 1'b1;
        tick(200);
        stat_reads = 0;
        foreach (bus_log[k]) if (bus_log[k][9:8] == 2'b10) stat_reads++;
        n_cmp++;
        if (stat_reads < 10) begin n_err++; $display("FAIL tdre_polls got=%0d want>=10", stat_reads); end
        n_cmp++;
        if (tx_log.size() !== 0 || ack_log.size() !== 0) begin
            n_err++; $display("FAIL tdre_blocked got=%0d writes %0d acks want=0 0", tx_log.size(), ack_log.size());
        end
        m_tdre_low = 1'b0;
        for (int i = 0; i < 300 && ack_log.size() < 1; i++) tick(1);
        req1 = 1'b0;
        tick(100);
        n_cmp++;
        if (tx_log.size() !== 1 || tx_log[0] !== 8'h33) begin
            n_err++; $display("FAIL tdre_release_tx got=%0d first=%02h want=1 33", tx_log.size(), tx_log[0]);
        end
        n_cmp++;
        if (ack_log.size() !== 1 || ack_log[0] !== 1) begin
            n_err++; $display("FAIL tdre_release_ack got=%0d first=%0d want=1 ack1", ack_log.size(), ack_log[0]);
        end
    endtask

    task automatic test_rx_priority();
        clear_logs();
        m_rdr = 8'h5C;
        m_err = 2'b10;
        m_rdrf = 1'b1;
        data1 = 8'h44;
        req1 = 1'b1;
        for (int i = 0; i < 300 && ack_log.size() < 1; i++) tick(1);
        req1 = 1'b0;
        tick(60);
        m_err = 2'b00;
        n_cmp++;
        if (rx_log.size() !== 1 || rx_log[0] !== {2'b10, 8'h5C}) begin
            n_err++; $display("FAIL prio_rx got=%0d first=%03h want=1 25C", rx_log.size(), rx_log[0]);
        end
        n_cmp++;
        if (!(rx_cyc > 0 && ack_cyc > rx_cyc)) begin
            n_err++; $display("FAIL prio_order got rx@%0d ack@%0d want rx before ack", rx_cyc, ack_cyc);
        end
        n_cmp++;
        if (tx_log.size() !== 1 || tx_log[0] !== 8'h44 || ack_log[0] !== 1) begin
            n_err++; $display("FAIL prio_tx got=%0d first=%02h ack=%0d want=1 44 ack1", tx_log.size(), tx_log[0], ack_log[0]);
        end
    endtask

    task automatic test_reset_mid_write();
        clear_logs();
        data0 = 8'h66;
        req0 = 1'b1;
        for (int i = 0; i < 300 && !(acia_sel && acia_rs && !acia_rw); i++) tick(1);
        n_cmp++;
        if (!(acia_sel && acia_rs && !acia_rw)) begin n_err++; $display("FAIL midrst_start got no TDR cycle want one"); end
        tick(5);
        reset = 1'b1;
        tick(1);
        n_cmp++;
        if ({acia_sel, acia_E, init_done} !== 3'b000) begin
            n_err++; $display("FAIL midrst_drop got sel/E/init=%03b want=000", {acia_sel, acia_E, init_done});
        end
        tick(2);
        bus_log.delete();
        reset = 1'b0;
        for (int i = 0; i < 100 && bus_log.size() < 1; i++) tick(1);
        n_cmp++;
        if (bus_log[0] !== 10'h003) begin n_err++; $display("FAIL midrst_mr got=%03h want=003", bus_log[0]); end
        n_cmp++;
        if (ack_log.size() !== 0 || tx_log.size() !== 0) begin
            n_err++; $display("FAIL midrst_noack got=%0d acks %0d writes want=0 0", ack_log.size(), tx_log.size());
        end
        for (int i = 0; i < 400 && ack_log.size() < 1; i++) tick(1);
        req0 = 1'b0;
        tick(60);
        n_cmp++;
        if (ack_log.size() !== 1 || tx_log[0] !== 8'h66) begin
            n_err++; $display("FAIL midrst_retry got=%0d acks first=%02h want=1 66", ack_log.size(), tx_log[0]);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_loopback();
        test_round_robin();
        test_tdre_block();
        test_rx_priority();
        test_reset_mid_write();
        n_cmp++;
        if (viol !== 0) begin n_err++; $display("FAIL protocol_violations got=%0d want=0", viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
